poly_compress_pack: RTL

- Downstream consumer of the polyvec base-multiply/accumulate stage.
- After that stage's `done`, it reads the 256 reduced coefficients from accumulator RAM C.
- Per coefficient: normalises it into [0,q), compresses it to D_BITS bits, and packs the results LSB-first into a byte stream.
- Byte stream uses a valid/ready handshake and feeds the ciphertext/serialiser stage.

---
 rtl/poly_compress_pack.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/poly_compress_pack.sv
// Reads 256 coefficients from accumulator RAM C, normalises each into [0,q),
// compresses it to D_BITS bits and packs the codes LSB-first into a handshaked byte stream.
module poly_compress_pack #(
  parameter int D_BITS  = 4,
  parameter int KYBER_Q = 3329,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             start,
  output logic             rd_en,
  output logic [DEPTH-1:0] rd_addr,
  input  logic [15:0]      rd_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, RD, LAT, CMP, EMIT, FIN} state_t;

  // floor(n/q) == (n*RECIP) >> 35 holds exactly for every n below 2^23
  localparam logic [23:0]      RECIP    = 24'(((64'd1 << 35) + 64'(KYBER_Q) - 64'd1) / 64'(KYBER_Q));
  localparam logic [16:0]      Q17      = 17'(KYBER_Q);
  localparam logic [23:0]      HALF_Q   = 24'(KYBER_Q / 2);
  localparam logic [DEPTH-1:0] LAST_IDX = '1;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] idx_q, idx_d;
  logic [17:0]      acc_q, acc_d;
  logic [4:0]       bits_q, bits_d;
  logic [15:0]      x_q, x_d;
  logic             rd_en_q, rd_en_d;
  logic [DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [16:0]       x_ext, x_pos;
  logic [11:0]       x_norm;
  logic [23:0]       num;
  logic [47:0]       prod;
  logic [D_BITS-1:0] c;
  logic [17:0]       c_shift;

  always_comb begin
    x_ext   = {x_q[15], x_q};
    x_pos   = x_ext[16] ? x_ext + Q17 : x_ext;
    x_norm  = (x_pos >= Q17) ? 12'(x_pos - Q17) : 12'(x_pos);
    num     = ({12'd0, x_norm} << D_BITS) + HALF_Q;
    prod    = 48'(num) * 48'(RECIP);
    c       = D_BITS'(prod >> 35);
    c_shift = 18'(c) << bits_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    bits_d      = bits_q;
    x_d         = x_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = RD;
        busy_d    = 1'b1;
        idx_d     = '0;
        acc_d     = '0;
        bits_d    = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      RD:  state_d = LAT;
      LAT: begin
        x_d     = rd_data;
        state_d = CMP;
      end
      CMP: begin
        acc_d       = acc_q | c_shift;
        bits_d      = bits_q + 5'(D_BITS);
        out_valid_d = (bits_d >= 5'd8);
        out_data_d  = acc_d[7:0];
        state_d     = EMIT;
      end
      EMIT: begin
        // out_valid_q mirrors bits_q >= 8 for the whole time we sit in EMIT
        if (out_valid_q) begin
          if (out_ready) begin
            acc_d       = acc_q >> 8;
            bits_d      = bits_q - 5'd8;
            out_valid_d = (bits_d >= 5'd8);
            out_data_d  = acc_d[7:0];
          end
        end else if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d     = idx_q + 1'b1;
          rd_addr_d = idx_q + 1'b1;
          rd_en_d   = 1'b1;
          state_d   = RD;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      bits_q      <= '0;
      x_q         <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (set) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      bits_q      <= bits_d;
      x_q         <= x_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
